// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Holds the state enum, opcode constants, ALU op codes and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JUMP,
    S_LINK,
    S_LUI,
    S_HALT
  } state_t;

  typedef enum logic {
    CLS_R,
    CLS_I
  } alu_class_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_ALU    = 2'b01;
  localparam logic [1:0] RES_MDR    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic branch_taken(input logic [2:0] func3, input logic zer, input logic neg);
    case (func3)
      3'b000:  return zer;
      3'b001:  return !zer;
      3'b100:  return neg;
      3'b101:  return !neg;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in, enables and selects out.
// master = controller, slave = datapath.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zer;
  logic       neg;
  logic       pcen;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [2:0] aluop;
  logic [1:0] resultsrc;
  logic [2:0] immsrc;
  logic       retire;
  logic       illegal;

  modport master (
    input  opcode, func3, func7, zer, neg,
    output pcen, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb,
           aluop, resultsrc, immsrc, retire, illegal
  );

  modport slave (
    output opcode, func3, func7, zer, neg,
    input  pcen, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb,
           aluop, resultsrc, immsrc, retire, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode for R/I-type arithmetic; flags shift and unknown func7 encodings.
// Purely combinational, no backpressure.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_t cls,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [2:0] aluop,
  output logic       illegal
);

  always_comb begin
    aluop   = ALU_ADD;
    illegal = 1'b0;
    case (func3)
      3'b000:  aluop = (cls == CLS_R && func7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b010:  aluop = ALU_SLT;
      3'b011:  aluop = ALU_SLTU;
      3'b100:  aluop = ALU_XOR;
      3'b110:  aluop = ALU_OR;
      3'b111:  aluop = ALU_AND;
      default: illegal = 1'b1;
    endcase
    // func7 only qualifies R-type; for I-type those bits are immediate
    if (cls == CLS_R) begin
      if (func7 == F7_ALT) begin
        if (func3 != 3'b000) illegal = 1'b1;
      end else if (func7 != F7_BASE) begin
        illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM, Moore outputs one state per cycle; CTRL_ILLEGAL_HALT_EN makes illegal sticky.
// Latency: outputs decode from current state; no backpressure, rst forces all write enables low.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.master ctrl
);

  logic [STATE_W-1:0] state_q;
  state_t             state;
  state_t             state_d;

  logic [2:0] dec_aluop;
  logic       dec_bad;
  logic       decode_ok;

  logic       pcen, adrsrc, memwrite, irwrite, regwrite, retire, illegal;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic [2:0] aluop, immsrc;

  assign state = state_t'(state_q[3:0]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= STATE_W'(S_FETCH);
    else     state_q <= STATE_W'(state_d);
  end

  alu_decoder u_alu_decoder (
    .cls     ((ctrl.opcode == OP_R) ? CLS_R : CLS_I),
    .func3   (ctrl.func3),
    .func7   (ctrl.func7),
    .aluop   (dec_aluop),
    .illegal (dec_bad)
  );

  always_comb begin
    decode_ok = 1'b0;
    case (ctrl.opcode)
      OP_LOAD, OP_STORE: decode_ok = (ctrl.func3 == 3'b010);
      OP_R, OP_I:        decode_ok = !dec_bad;
      OP_BRANCH:         decode_ok = (ctrl.func3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      OP_JAL, OP_LUI:    decode_ok = 1'b1;
      OP_JALR:           decode_ok = (ctrl.func3 == 3'b000);
      default:           decode_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = S_FETCH;
    pcen      = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_REGB;
    aluop     = ALU_ADD;
    resultsrc = RES_ALUOUT;
    immsrc    = IMM_I;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        irwrite   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        pcen      = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // branch target is computed speculatively into ALUout here
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        immsrc  = IMM_B;
        if (!decode_ok) begin
          illegal = 1'b1;
`ifdef CTRL_ILLEGAL_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          case (ctrl.opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_I:              state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL, OP_JALR:   state_d = S_JUMP;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alusrca = SRCA_REGA;
        alusrcb = SRCB_IMM;
        immsrc  = (ctrl.opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (ctrl.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_MDR;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        retire   = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_REGA;
        alusrcb = SRCB_REGB;
        aluop   = dec_aluop;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = SRCA_REGA;
        alusrcb = SRCB_IMM;
        immsrc  = IMM_I;
        aluop   = dec_aluop;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        resultsrc = RES_ALUOUT;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alusrca   = SRCA_REGA;
        alusrcb   = SRCB_REGB;
        aluop     = ALU_SUB;
        resultsrc = RES_ALUOUT;
        pcen      = branch_taken(ctrl.func3, ctrl.zer, ctrl.neg);
        retire    = 1'b1;
      end
      S_JUMP: begin
        // PC is redirected before rd is written so jalr with rd==rs1 sees the old rs1
        alusrca   = (ctrl.opcode == OP_JALR) ? SRCA_REGA : SRCA_OLDPC;
        alusrcb   = SRCB_IMM;
        immsrc    = (ctrl.opcode == OP_JALR) ? IMM_I : IMM_J;
        resultsrc = RES_ALU;
        pcen      = 1'b1;
        state_d   = S_LINK;
      end
      S_LINK: begin
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      S_LUI: begin
        immsrc    = IMM_U;
        resultsrc = RES_IMM;
        regwrite  = 1'b1;
        retire    = 1'b1;
      end
      S_HALT: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ctrl.pcen      = pcen & ~rst;
  assign ctrl.adrsrc    = adrsrc;
  assign ctrl.memwrite  = memwrite & ~rst;
  assign ctrl.irwrite   = irwrite & ~rst;
  assign ctrl.regwrite  = regwrite & ~rst;
  assign ctrl.alusrca   = alusrca;
  assign ctrl.alusrcb   = alusrcb;
  assign ctrl.aluop     = aluop;
  assign ctrl.resultsrc = resultsrc;
  assign ctrl.immsrc    = immsrc;
  assign ctrl.retire    = retire & ~rst;
  assign ctrl.illegal   = illegal & ~rst;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multicycle RV32I datapath. It takes opcode/func3/func7 from the instruction register and zer/neg from the ALU, and drives every datapath enable and mux select, one state per cycle. It sits directly beside the datapath and is its only source of control. Supported instructions:
- R-type and I-type ALU: add/sub/and/or/xor/slt/sltu and their immediate forms
- lw, sw
- beq, bne, blt, bge
- jal, jalr, lui

Parameters:
STATE_W, 4, state register width; must be >= 4.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode  in  7  instr[6:0]
func3  in  3  instr[14:12]
func7  in  7  instr[31:25]
zer  in  1  ALU zero flag
neg  in  1  ALU negative flag
pcen  out  1  PC load enable
adrsrc  out  1  memory address select: 0=PC, 1=registered ALU out
memwrite  out  1  memory write enable
irwrite  out  1  IR/oldPC load enable
regwrite  out  1  register file write enable
alusrca  out  2  ALU A select: 00=PC, 01=oldPC, 10=regA, 11=0
alusrcb  out  2  ALU B select: 00=regB, 01=imm, 10=4, 11=0
aluop  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sltu
resultsrc  out  2  result select: 00=ALUout reg, 01=ALU result, 10=MDR, 11=imm
immsrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
retire  out  1  one-cycle pulse in the last state of each instruction
illegal  out  1  one-cycle pulse in DECODE on an unsupported encoding

Behaviour:
- Reset: one clock (clk); synchronous active-high reset (rst). While rst=1: state<=FETCH and pcen/memwrite/irwrite/regwrite/retire/illegal are forced to 0. The first cycle after release is FETCH.
- Outputs are Moore-decoded from state. Only pcen in BRANCH also depends on zer/neg/func3. Fields not listed below are 0.
- Memory read is combinational. Regs A/B, ALUout and MDR load every cycle.
- FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=01, pcen=1 (PC<=PC+4). Next state: DECODE.
- DECODE: alusrca=01, alusrcb=01, immsrc=B, add (branch target into ALUout). Dispatch by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 or 1100111 -> JUMP
  - 0110111 -> LUI
  - anything else -> illegal=1, FETCH
- MEMADR: alusrca=10, alusrcb=01, immsrc=I (lw) or S (sw), add. Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adrsrc=1. Next: MEMWB.
- MEMWB: resultsrc=10, regwrite=1, retire. Next: FETCH.
- MEMWRITE: adrsrc=1, memwrite=1, retire. Next: FETCH.
- EXECR: alusrca=10, alusrcb=00, aluop from func3/func7. Next: ALUWB.
- EXECI: alusrca=10, alusrcb=01, immsrc=I, aluop from func3 (never sub). Next: ALUWB.
- ALUWB: resultsrc=00, regwrite=1, retire. Next: FETCH.
- BRANCH: alusrca=10, alusrcb=00, sub, resultsrc=00, retire. pcen is:
  - zer for func3 000
  - !zer for 001
  - neg for 100
  - !neg for 101
  Next: FETCH.
- JUMP: resultsrc=01, add, pcen=1.
  - jal: alusrca=01, immsrc=J, alusrcb=01
  - jalr: alusrca=10, immsrc=I, alusrcb=01
  Next: LINK.
- LINK: alusrca=01, alusrcb=10, add, resultsrc=01, regwrite=1, retire (rd<=oldPC+4). The PC is written before rd, so jalr with rd==rs1 is correct. Bit 0 of the jalr target is not cleared; misaligned targets are out of scope. Next: FETCH.
- LUI: immsrc=U, resultsrc=11, regwrite=1, retire. Next: FETCH.
- ALU op decode, func3 -> aluop:
  - 000 -> add, or sub when R-type and func7=0100000
  - 010 -> slt
  - 011 -> sltu
  - 100 -> xor
  - 110 -> or
  - 111 -> and
- Illegal encodings, all detected in DECODE:
  - ALU func3 001 or 101
  - R-type func7 other than 0000000, or 0100000 with func3!=000
  - branch func3 010, 011, 110 or 111
  - jalr func3!=000
  - lw func3!=010, sw func3!=010
- Cycles per instruction: ALU 4, lw 5, sw 4, branch 3, jal/jalr 4, lui 3.
- rst asserted mid-instruction aborts it: no further write enables, and the next state is FETCH.

Optional Feature:
CTRL_ILLEGAL_HALT_EN:
- Defined: an illegal encoding enters a sticky HALT state. In HALT all enables are 0, illegal stays 1, and only rst exits.
- Undefined: the illegal instruction acts as a NOP; illegal pulses for one cycle and the FSM returns to FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode constants
  - aluop codes
  - alusrca/alusrcb/resultsrc/immsrc select codes
- Sub-module alu_decoder: inputs opcode class, func3, func7; outputs aluop and an illegal flag.

Test Plan:
- rst=1 for 2 cycles -> all enables 0. First cycle after release: pcen=1, irwrite=1, alusrca=00, alusrcb=10, aluop=000, resultsrc=01.
- add (0110011/000/0000000) -> FETCH, DECODE, EXECR (aluop 000), ALUWB (regwrite=1, retire=1); 4 cycles. With func7=0100000, EXECR aluop=001.
- lw (0000011/010) -> 5 cycles; MEMADR immsrc=000; MEMREAD adrsrc=1; MEMWB resultsrc=10, regwrite=1. sw (0100011/010) -> 4 cycles; MEMWRITE memwrite=1, immsrc=001.
- beq with zer=1 -> BRANCH pcen=1, resultsrc=00. beq with zer=0 -> pcen=0. blt with neg=1 -> pcen=1. bge with neg=1 -> pcen=0. Each takes 3 cycles.
- jal (1101111) -> JUMP: pcen=1, alusrca=01, immsrc=011. Then LINK: regwrite=1, alusrca=01, alusrcb=10. jalr (1100111/000) -> JUMP with alusrca=10, immsrc=000. lui (0110111) -> 3 cycles, resultsrc=11, immsrc=100.
- Opcode 0000000 -> illegal=1 in DECODE, then FETCH. With CTRL_ILLEGAL_HALT_EN: HALT, enables stay 0 for 10+ cycles, and rst returns the FSM to FETCH.
